// File: rtl/float_cmp_pkg.sv
// Shared types for the float compare/reduce unit.
// Mode encodings, reduction FSM states, qNaN constant builder.
package float_cmp_pkg;

  typedef enum logic [2:0] {
    M_GT  = 3'd0,
    M_LT  = 3'd1,
    M_GE  = 3'd2,
    M_LE  = 3'd3,
    M_EQ  = 3'd4,
    M_NE  = 3'd5,
    M_MIN = 3'd6,
    M_MAX = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Canonical qNaN: sign 0, exponent all ones, mantissa MSB set.
  // Returned right-aligned in 64 bits; callers slice to DATA_W.
  function automatic logic [63:0] qnan_f(input int dw, input int ew);
    logic [63:0] ones;
    ones = (64'd1 << (ew + 1)) - 64'd1;
    return ones << (dw - ew - 2);
  endfunction

endpackage

// File: rtl/float_cmp_core.sv
// Combinational classify + sign-magnitude compare of two floats.
// Ports: a, b operands; a_nan, b_nan, eq (ordered), gt (ordered).
module float_cmp_core
  import float_cmp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              a_nan,
  output logic              b_nan,
  output logic              eq,
  output logic              gt
);

  localparam int MAN_W = DATA_W - EXP_W - 1;

  logic              sa;
  logic              sb;
  logic [DATA_W-2:0] ma;
  logic [DATA_W-2:0] mb;
  logic              zz;

  always_comb begin
    sa    = a[DATA_W-1];
    sb    = b[DATA_W-1];
    ma    = a[DATA_W-2:0];
    mb    = b[DATA_W-2:0];
    a_nan = (&a[DATA_W-2:MAN_W]) & (|a[MAN_W-1:0]);
    b_nan = (&b[DATA_W-2:MAN_W]) & (|b[MAN_W-1:0]);
    // +0 and -0 are the same value
    zz    = ~|ma & ~|mb;
    eq    = zz | (a == b);
    gt    = 1'b0;
    if (!zz) begin
      if (sa != sb)
        gt = ~sa;
      else if (sa)
        gt = ma < mb;
      else
        gt = ma > mb;
    end
  end

endmodule

// File: rtl/float_cmp_reduce.sv
// Float compare/min/max per element (2-stage) and arg-min/max reduction.
// Ports: clk, rst, run, running, mode, reduce, len, in0, in1 -> out0, out1, out2, done.
module float_cmp_reduce
  import float_cmp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              running,
  input  logic [2:0]        mode,
  input  logic              reduce,
  input  logic [CNT_W-1:0]  len,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [CNT_W-1:0]  out2,
  output logic              done
);

  localparam logic [DATA_W-1:0] QNAN =
    DATA_W'(qnan_f(DATA_W, EXP_W));

  mode_e             mode_q;
  logic              red_q;
  logic [CNT_W-1:0]  len_q;

  mode_e             mode_in;
  logic              red_in;
  logic              adv;

  assign mode_in = mode_e'(mode);
  assign red_in  = reduce & (mode_in == M_MIN | mode_in == M_MAX);
  // the run cycle itself never consumes data
  assign adv     = running & ~run;

  // ---------------- per-element path ----------------
  logic              c_an;
  logic              c_bn;
  logic              c_eq;
  logic              c_gt;

  float_cmp_core #(
    .DATA_W(DATA_W),
    .EXP_W (EXP_W)
  ) u_pe (
    .a    (in0),
    .b    (in1),
    .a_nan(c_an),
    .b_nan(c_bn),
    .eq   (c_eq),
    .gt   (c_gt)
  );

  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  mode_e             s1_mode;
  logic              s1_an;
  logic              s1_bn;
  logic              s1_eq;
  logic              s1_gt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a    <= '0;
      s1_b    <= '0;
      s1_mode <= M_GT;
      s1_an   <= 1'b0;
      s1_bn   <= 1'b0;
      s1_eq   <= 1'b0;
      s1_gt   <= 1'b0;
    end else if (adv) begin
      s1_a    <= in0;
      s1_b    <= in1;
      s1_mode <= mode_q;
      s1_an   <= c_an;
      s1_bn   <= c_bn;
      s1_eq   <= c_eq;
      s1_gt   <= c_gt;
    end
  end

  logic              s1_nan;
  logic              s1_lt;
  logic [DATA_W-1:0] mm;
  logic [DATA_W-1:0] res;

  always_comb begin
    s1_nan = s1_an | s1_bn;
    s1_lt  = ~s1_gt & ~s1_eq;
    if (s1_an & s1_bn)
      mm = QNAN;
    else if (s1_an)
      mm = s1_b;
    else if (s1_bn)
      mm = s1_a;
    else if (s1_mode == M_MIN)
      mm = (s1_lt | s1_eq) ? s1_a : s1_b;
    else
      mm = (s1_gt | s1_eq) ? s1_a : s1_b;
    res = '0;
    unique case (s1_mode)
      M_GT:  res = {DATA_W{s1_gt & ~s1_nan}};
      M_LT:  res = {DATA_W{s1_lt & ~s1_nan}};
      M_GE:  res = {DATA_W{(s1_gt | s1_eq) & ~s1_nan}};
      M_LE:  res = {DATA_W{(s1_lt | s1_eq) & ~s1_nan}};
      M_EQ:  res = {DATA_W{s1_eq & ~s1_nan}};
      M_NE:  res = {DATA_W{~s1_eq | s1_nan}};
      M_MIN: res = mm;
      M_MAX: res = mm;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out0 <= '0;
    else if (adv && !red_q)
      out0 <= res;
  end

  // ---------------- reduction path ----------------
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic              r_an;
  logic              acc_nan;
  logic              r_eq;
  logic              r_gt;
  logic              beats;
  logic              win;

  float_cmp_core #(
    .DATA_W(DATA_W),
    .EXP_W (EXP_W)
  ) u_red (
    .a    (in0),
    .b    (acc),
    .a_nan(r_an),
    .b_nan(acc_nan),
    .eq   (r_eq),
    .gt   (r_gt)
  );

  // acc holds qNaN until the first number lands, so that is "empty"
  always_comb begin
    if (mode_q == M_MAX)
      beats = r_gt;
    else
      beats = ~r_gt & ~r_eq;
    win = ~r_an & (acc_nan | beats);
  end

  state_e state_q;
  state_e state_d;
  logic   take;
  logic   fin;

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_SCAN: begin
        if (running) begin
          take = 1'b1;
          if (cnt == len_q - CNT_W'(1))
            state_d = S_DONE;
        end
      end
      S_DONE: begin
        fin     = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (run) begin
      take = 1'b0;
      fin  = 1'b0;
      if (!red_in)
        state_d = S_IDLE;
      else if (len == '0)
        state_d = S_DONE;
      else
        state_d = S_SCAN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_GT;
      red_q   <= 1'b0;
      len_q   <= '0;
      acc     <= QNAN;
      idx     <= '0;
      cnt     <= '0;
      out1    <= '0;
      out2    <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= fin;
      if (run) begin
        mode_q <= mode_in;
        red_q  <= red_in;
        len_q  <= len;
        acc    <= QNAN;
        idx    <= '0;
        cnt    <= '0;
      end else if (take) begin
        cnt <= cnt + CNT_W'(1);
        if (win) begin
          acc <= in0;
          idx <= cnt;
        end
      end
      if (fin) begin
        out1 <= acc;
        out2 <= idx;
      end
    end
  end

endmodule

// File: tb/tb_float_cmp_reduce.sv
// Scoreboard bench for float_cmp_reduce.
// Directed per-element vectors and reductions, monitor-side checking.
module tb_float_cmp_reduce;

  localparam int DW = 32;
  localparam int CW = 16;
  localparam logic [DW-1:0] ONES = 32'hFFFF_FFFF;
  localparam logic [DW-1:0] QN   = 32'h7FC0_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          running = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic          reduce = 1'b0;
  logic [CW-1:0] len = '0;
  logic [DW-1:0] in0 = '0;
  logic [DW-1:0] in1 = '0;
  logic [DW-1:0] out0;
  logic [DW-1:0] out1;
  logic [CW-1:0] out2;
  logic          done;

  always #5 clk = ~clk;

  float_cmp_reduce #(
    .DATA_W(DW),
    .EXP_W (8),
    .CNT_W (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .running(running),
    .mode   (mode),
    .reduce (reduce),
    .len    (len),
    .in0    (in0),
    .in1    (in1),
    .out0   (out0),
    .out1   (out1),
    .out2   (out2),
    .done   (done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic [DW-1:0] val;
    logic [CW-1:0] idx;
    logic [31:0]   at;
  } red_t;

  logic [DW-1:0] pe_q[$];
  red_t          red_q[$];

  logic       issue = 1'b0;
  logic [1:0] vp = 2'b00;
  logic       chk = 1'b0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // issue tags travel two advancing cycles to reach out0
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (running && !run) begin
      vp  <= {vp[0], issue};
      chk <= vp[0];
    end else begin
      chk <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic [DW-1:0] e;
    red_t r;
    if (!rst) begin
      if (chk) begin
        if (pe_q.size() == 0) begin
          check("pe_unexpected", 1, 0);
        end else begin
          e = pe_q.pop_front();
          check("pe_out0", out0, e);
        end
      end
      if (done) begin
        if (red_q.size() == 0) begin
          check("red_unexpected_done", 1, 0);
        end else begin
          r = red_q.pop_front();
          check("red_out1", out1, r.val);
          check("red_out2", out2, r.idx);
          check("red_cycle", cyc, r.at);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pe_run(input logic [2:0] m);
    run = 1'b1; mode = m; reduce = 1'b0;
    running = 1'b1; issue = 1'b0;
    tick();
    run = 1'b0;
  endtask

  task automatic pe_vec(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] exp);
    in0 = a; in1 = b; running = 1'b1; issue = 1'b1;
    pe_q.push_back(exp);
    tick();
    issue = 1'b0;
  endtask

  task automatic red_start(input logic [2:0] m, input logic [CW-1:0] n);
    run = 1'b1; mode = m; reduce = 1'b1; len = n;
    running = 1'b1; issue = 1'b0;
    tick();
    run = 1'b0;
  endtask

  task automatic samp(input logic [DW-1:0] a);
    in0 = a; running = 1'b1;
    tick();
  endtask

  task automatic wait_red(input string nm);
    for (int i = 0; i < 30; i++) begin
      if (red_q.size() == 0) break;
      tick();
    end
    check(nm, red_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("rst_out0", out0, 0);
    check("rst_out1", out1, 0);
    check("rst_out2", out2, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    pe_run(3'd0);
    pe_vec(32'h3F80_0000, 32'hBF80_0000, ONES);
    pe_vec(32'hBF80_0000, 32'h3F80_0000, 32'h0);
    pe_run(3'd1);
    pe_vec(32'hC000_0000, 32'hBF80_0000, ONES);
    pe_vec(32'h0000_0000, 32'h8000_0000, 32'h0);
    pe_run(3'd4);
    pe_vec(32'h8000_0000, 32'h0000_0000, ONES);
    pe_vec(32'h3F80_0000, 32'h3F80_0001, 32'h0);
    pe_run(3'd5);
    pe_vec(32'h7FC0_0000, 32'h7FC0_0000, ONES);
    pe_run(3'd2);
    pe_vec(32'h7FC0_0000, 32'h3F80_0000, 32'h0);
    pe_vec(32'h4000_0000, 32'h4000_0000, ONES);
    pe_run(3'd3);
    pe_vec(32'hFF80_0000, 32'hBF80_0000, ONES);
    pe_run(3'd7);
    pe_vec(32'h7FC0_0001, 32'h4000_0000, 32'h4000_0000);
    running = 1'b0;
    tick();
    tick();
    pe_vec(32'h7FC0_0001, 32'hFFC0_0000, QN);
    pe_vec(32'hBF80_0000, 32'hC000_0000, 32'hBF80_0000);
    pe_run(3'd6);
    pe_vec(32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    pe_vec(32'h8000_0000, 32'h0000_0000, 32'h8000_0000);
    tick();
    tick();
    tick();
    check("pe_drained", pe_q.size(), 0);

    red_q.push_back('{val: 32'h4040_0000, idx: 16'd1, at: 32'(cyc + 7)});
    red_start(3'd7, 16'd5);
    samp(32'h3F80_0000);
    samp(32'h4040_0000);
    samp(32'h7FC0_0000);
    samp(32'h4040_0000);
    samp(32'hC000_0000);
    wait_red("red_max_timeout");
    check("out0_hold", out0, 32'h8000_0000);

    red_q.push_back('{val: 32'hBF80_0000, idx: 16'd1, at: 32'(cyc + 9)});
    red_start(3'd6, 16'd4);
    samp(32'h4000_0000);
    samp(32'hBF80_0000);
    running = 1'b0;
    tick();
    tick();
    tick();
    samp(32'h3F00_0000);
    samp(32'hBF80_0000);
    wait_red("red_min_timeout");

    red_start(3'd7, 16'd3);
    samp(32'h40A0_0000);
    samp(32'h3F80_0000);
    red_q.push_back('{val: QN, idx: 16'd0, at: 32'(cyc + 2)});
    red_start(3'd7, 16'd0);
    check("abort_old_out1", out1, 32'hBF80_0000);
    wait_red("red_len0_timeout");

    red_start(3'd7, 16'd10);
    samp(32'h4000_0000);
    samp(32'h4040_0000);
    running = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_out0", out0, 0);
    check("arst_out1", out1, 0);
    check("arst_out2", out2, 0);
    check("arst_done", done, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("red_q_empty", red_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/float_cmp_reduce.md
# float_cmp_reduce

Parametrised floating-point compare and reduce unit for the Versat datapath. It has two modes. In per-element mode it produces a registered predicate or min/max over two input streams. In reduction mode it scans a stream of `LEN` elements and reports the arg-max or arg-min value and its index. It plugs into the accelerator through the standard `run`/`running` control pair, alongside the other float units.

## Interface
Parameters:
- `DATA_W`, 32: total float width (sign + exponent + mantissa).
- `EXP_W`, 8: exponent width; mantissa width is `DATA_W-EXP_W-1`.
- `CNT_W`, 16: width of the length and index counters.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `run`, in, 1: one-cycle start pulse; latches config and clears reduction state.
- `running`, in, 1: data-valid enable; no state advances while low.
- `mode`, in, 3: operation, sampled at `run`: GT=0, LT=1, GE=2, LE=3, EQ=4, NE=5, MIN=6, MAX=7.
- `reduce`, in, 1: sampled at `run`; 1 selects reduction over `in0` (MIN/MAX modes only).
- `len`, in, `CNT_W`: number of elements to reduce, sampled at `run`.
- `in0`, in, `DATA_W`: operand A / reduction sample.
- `in1`, in, `DATA_W`: operand B (ignored in reduction).
- `out0`, out, `DATA_W`: per-element result: predicate replicated to all bits, or selected min/max value.
- `out1`, out, `DATA_W`: reduction result value.
- `out2`, out, `CNT_W`: reduction result index (zero-based).
- `done`, out, 1: one-cycle pulse when reduction completes.

## Operation
- Classification: NaN = exponent all ones and mantissa nonzero. ±0 compare equal.
- Ordering: sign-magnitude compare. Both negative: the smaller magnitude is greater.
- Predicates:
  - GT/LT/GE/LE/EQ are false if either operand is NaN.
  - NE is true if either operand is NaN.
- MIN/MAX, per element:
  - One operand NaN: return the other operand.
  - Both NaN: return canonical qNaN (sign 0, exponent all ones, mantissa MSB 1, rest 0).
  - Equal values, including ±0: return `in0`.
- Reduction state machine:
  - States IDLE, SCAN, DONE.
  - `run` from any state: load config, accumulator = qNaN, valid = 0, count = 0, go to SCAN.
  - If latched `len`=0, go directly to DONE instead.
  - SCAN, each cycle with `running`=1:
    - Compare `in0` against the accumulator. If valid is 0 or `in0` wins strictly, load the accumulator and index = count.
    - NaN samples never win, and never set valid.
    - count += 1. When count reaches `len`-1 and that sample is consumed, go to DONE.
  - Ties keep the earliest index.
  - DONE: `done`=1 for one cycle. `out1`/`out2` update with `done` and hold until the next `run`. Then go to IDLE.
  - All-NaN stream: `out1` = qNaN, `out2` = 0.
- Reduction disables `out0` updates; `out0` holds its last value.
- `reduce`=1 with a predicate mode: treated as `reduce`=0.

## Timing
- Reset values: `out0`=0, `out1`=0, `out2`=0, `done`=0, state IDLE, config = GT / non-reduce / `len` 0.
- Per-element latency is 2 cycles:
  - Stage 1 registers classification and magnitude compare.
  - Stage 2 registers `out0`.
  - Operands presented at cycle t appear at t+2 when `running` is held.
- The pipeline advances only when `running`=1. Stalls freeze both stages.
- Reduction: with `running` continuously high after `run` at cycle t, samples arrive at t+1 … t+`len`, and `done` rises at t+`len`+2.
- `run` coincident with `running`: the `run` cycle's data is not consumed.
- `run` mid-scan: abort immediately with no `done` pulse; the old result stays visible until the new `done`.
- Counter: `len`=2^`CNT_W`-1 is supported; no wrap occurs.
- `rst` mid-operation: return to reset values asynchronously.

## Structure
- Package `float_cmp_pkg`: mode encodings, state enum, qNaN constant function of `DATA_W`/`EXP_W`.
- Sub-module `float_cmp_core`: combinational classify plus ordered/unordered compare, instantiated twice (per-element path and reduction accumulator path).
- Top level: pipeline registers, FSM, counters.

## Test plan
- GT, `running`=1: in0=0x3F800000 (1.0), in1=0xBF800000 (-1.0) -> `out0`=0xFFFFFFFF two cycles later. Swapping the operands -> 0.
- EQ with in0=0x80000000, in1=0x00000000 -> all ones. NE with in0=0x7FC00000 -> all ones. GE with the same NaN -> 0.
- MAX: in0=0x7FC00001 (NaN), in1=0x40000000 -> 0x40000000. Both NaN -> 0x7FC00000.
- Reduce MAX, `len`=5, samples 1.0, 3.0, NaN, 3.0, -2.0 -> `done` at t+7, `out1`=0x40400000, `out2`=1.
- Reduce MIN, `len`=4, with `running` dropped for 3 cycles mid-stream -> `done` delayed by exactly 3 cycles, correct min and index.
- Reduction restarted by `run` after 2 samples, then `len`=0 -> no `done` from the aborted scan. Next cycle `done`, `out1`=0x7FC00000, `out2`=0. Asserting `rst` during SCAN clears all outputs.
